// File: rtl/i2c_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared widths and the arbiter state encoding for the I2C request
//   arbiter. Imported by rr_pick and i2c_req_arbiter.
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } arb_state_e;

endpackage : i2c_pkg

// File: rtl/i2c_req_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Starting at ptr_i and wrapping, the
//   first requester with req_i set wins.
// Ports
//   req_i  in  NUM_REQ  request vector
//   ptr_i  in  IDX_W    highest-priority requester index
//   win_o  out NUM_REQ  one-hot winner (all zero when no request)
//   idx_o  out IDX_W    winner index (0 when no request)
//   any_o  out 1        at least one request pending
// ---------------------------------------------------------------------------
module rr_pick
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic found;
  int   pos;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    pos   = 0;
    // Walk the requesters in priority order ptr, ptr+1, ... wrapping at
    // NUM_REQ; the pointer never exceeds NUM_REQ-1, so one subtraction wraps.
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        idx_o      = IDX_W'(pos);
        win_o[pos] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
//   Shares one I2C master among NUM_REQ requesters. Round-robin grant,
//   request fields latched at grant, one transaction in flight, a one-cycle
//   done pulse to the granted requester with NACK / timeout / read data.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req/req_addr/req_rw/
//   req_wdata                per-requester request level and fields
//   grant                    one-hot, high from grant until the done pulse
//   done                     one-cycle completion pulse to the granted requester
//   resp_nack/resp_timeout/
//   resp_rdata               response, valid with done, held until next done
//   m_enable/m_address/
//   m_rw/m_data              command to the I2C master
//   m_busy/m_done/m_nack/
//   m_rdata                  status from the I2C master
// ---------------------------------------------------------------------------
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          resp_nack,
  output logic                          resp_timeout,
  output logic [I2C_DATA_W-1:0]         resp_rdata,
  output logic                          m_enable,
  output logic [I2C_ADDR_W-1:0]         m_address,
  output logic                          m_rw,
  output logic [I2C_DATA_W-1:0]         m_data,
  input  logic                          m_busy,
  input  logic                          m_done,
  input  logic                          m_nack,
  input  logic [I2C_DATA_W-1:0]         m_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    m_enable_q, m_enable_d;
  logic [I2C_ADDR_W-1:0]   m_address_q, m_address_d;
  logic                    m_rw_q, m_rw_d;
  logic [I2C_DATA_W-1:0]   m_data_q, m_data_d;
  logic                    resp_nack_q, resp_nack_d;
  logic                    resp_timeout_q, resp_timeout_d;
  logic [I2C_DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [NUM_REQ-1:0]      pick_win;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    done_d         = '0;
    gidx_d         = gidx_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    m_enable_d     = m_enable_q;
    m_address_d    = m_address_q;
    m_rw_d         = m_rw_q;
    m_data_d       = m_data_q;
    resp_nack_d    = resp_nack_q;
    resp_timeout_d = resp_timeout_q;
    resp_rdata_d   = resp_rdata_q;

    unique case (state_q)
      IDLE: begin
        // A master still busy from an aborted transaction blocks new grants.
        if (pick_any && !m_busy) begin
          state_d     = ISSUE;
          grant_d     = pick_win;
          gidx_d      = pick_idx;
          m_address_d = req_addr[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
          m_rw_d      = req_rw[pick_idx];
          m_data_d    = req_wdata[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
          m_enable_d  = 1'b1;
          cnt_d       = '0;
        end
      end

      ISSUE, WAIT_DONE: begin
        // Completion has priority over a timeout expiring in the same cycle.
        if (m_done) begin
          state_d        = RESPOND;
          grant_d        = '0;
          done_d         = grant_q;
          m_enable_d     = 1'b0;
          resp_nack_d    = m_nack;
          resp_timeout_d = 1'b0;
          resp_rdata_d   = (m_rw_q && !m_nack) ? m_rdata : '0;
        end else if (timeout_hit) begin
          state_d        = RESPOND;
          grant_d        = '0;
          done_d         = grant_q;
          m_enable_d     = 1'b0;
          resp_nack_d    = 1'b1;
          resp_timeout_d = 1'b1;
          resp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ISSUE && m_busy) begin
            state_d    = WAIT_DONE;
            m_enable_d = 1'b0;
          end
        end
      end

      RESPOND: begin
        state_d = IDLE;
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      done_q         <= '0;
      gidx_q         <= '0;
      ptr_q          <= '0;
      cnt_q          <= '0;
      m_enable_q     <= 1'b0;
      m_address_q    <= '0;
      m_rw_q         <= 1'b0;
      m_data_q       <= '0;
      resp_nack_q    <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      gidx_q         <= gidx_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      m_enable_q     <= m_enable_d;
      m_address_q    <= m_address_d;
      m_rw_q         <= m_rw_d;
      m_data_q       <= m_data_d;
      resp_nack_q    <= resp_nack_d;
      resp_timeout_q <= resp_timeout_d;
      resp_rdata_q   <= resp_rdata_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign resp_nack    = resp_nack_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_rdata   = resp_rdata_q;
  assign m_enable     = m_enable_q;
  assign m_address    = m_address_q;
  assign m_rw         = m_rw_q;
  assign m_data       = m_data_q;

endmodule : i2c_req_arbiter

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           resp_nack;
  logic           resp_timeout;
  logic [7:0]     resp_rdata;
  logic           m_enable;
  logic [6:0]     m_address;
  logic           m_rw;
  logic [7:0]     m_data;
  logic           m_busy;
  logic           m_done;
  logic           m_nack;
  logic [7:0]     m_rdata;

  i2c_req_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_wdata    (req_wdata),
    .grant        (grant),
    .done         (done),
    .resp_nack    (resp_nack),
    .resp_timeout (resp_timeout),
    .resp_rdata   (resp_rdata),
    .m_enable     (m_enable),
    .m_address    (m_address),
    .m_rw         (m_rw),
    .m_data       (m_data),
    .m_busy       (m_busy),
    .m_done       (m_done),
    .m_nack       (m_nack),
    .m_rdata      (m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       nack;
    logic       tmo;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (done !== '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done",         32'(done),         32'(1 << mon_e.idx));
          check("resp_nack",    32'(resp_nack),    32'(mon_e.nack));
          check("resp_timeout", 32'(resp_timeout), 32'(mon_e.tmo));
          check("resp_rdata",   32'(resp_rdata),   32'(mon_e.rdata));
          $display("txn done: requester=%0d nack=%0b timeout=%0b rdata=0x%02h grant=%b",
                   mon_e.idx, resp_nack, resp_timeout, resp_rdata, grant);
        end
      end
    end
  end

  // Wait (bounded) for m_enable, then check the grant and latched command.
  task automatic wait_grant(input int idx, input logic [6:0] addr, input logic rw, input logic [7:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (m_enable !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("m_enable_up", 32'(m_enable),  32'd1);
    check("grant",       32'(grant),     32'(1 << idx));
    check("m_address",   32'(m_address), 32'(addr));
    check("m_rw",        32'(m_rw),      32'(rw));
    check("m_data",      32'(m_data),    32'(wd));
  endtask

  // Master model: busy for 3 cycles, then a one-cycle m_done.
  task automatic serve(input logic nack, input logic [7:0] rdata);
    step();
    m_busy = 1'b1;
    step();
    check("m_enable_drop", 32'(m_enable), 32'd0);
    step();
    step();
    m_busy  = 1'b0;
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = rdata;
    step();
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic default_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7]  = 7'(8'h10 + i);
      req_wdata[8*i +: 8] = 8'(8'h80 + i);
    end
    req_rw = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst     = 1'b1;
    req     = '0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
    default_fields();

    step();
    check("rst_grant",     32'(grant),      32'd0);
    check("rst_done",      32'(done),       32'd0);
    check("rst_m_enable",  32'(m_enable),   32'd0);
    check("rst_resp_data", 32'(resp_rdata), 32'd0);
    check("rst_m_address", 32'(m_address),  32'd0);
    step();
    step();
    rst = 1'b0;

    // 1. single write, exact grant latency
    req_addr[6:0]  = 7'h50;
    req_wdata[7:0] = 8'hA5;
    req[0]         = 1'b1;
    sb.push_back('{idx: 0, nack: 1'b0, tmo: 1'b0, rdata: 8'h00});
    step();
    check("t1_grant_latency",    32'(grant),    32'b0001);
    check("t1_m_enable_latency", 32'(m_enable), 32'd1);
    wait_grant(0, 7'h50, 1'b0, 8'hA5);
    req[0] = 1'b0;
    serve(1'b0, 8'hEE);
    wait_drain();

    // 2. read on requester 2; fields changed after grant must not leak
    req_rw[2] = 1'b1;
    req[2]    = 1'b1;
    sb.push_back('{idx: 2, nack: 1'b0, tmo: 1'b0, rdata: 8'h3C});
    wait_grant(2, 7'h12, 1'b1, 8'h82);
    req[2]           = 1'b0;
    req_addr[20:14]  = 7'h7F;
    req_wdata[23:16] = 8'h00;
    @(negedge clk);
    check("t2_addr_held", 32'(m_address), 32'h12);
    check("t2_data_held", 32'(m_data),    32'h82);
    serve(1'b0, 8'h3C);
    wait_drain();

    // 4. NACK on a read from requester 3: rdata forced to 0
    req_rw[3] = 1'b1;
    req[3]    = 1'b1;
    sb.push_back('{idx: 3, nack: 1'b1, tmo: 1'b0, rdata: 8'h00});
    wait_grant(3, 7'h13, 1'b1, 8'h83);
    req[3] = 1'b0;
    serve(1'b1, 8'h77);
    wait_drain();

    // 3. round robin with all requests held; pointer is now 0
    default_fields();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{idx: k % N, nack: 1'b0, tmo: 1'b0, rdata: 8'h00});
      wait_grant(k % N, 7'(8'h10 + (k % N)), 1'b0, 8'(8'h80 + (k % N)));
      if (k == 4) begin
        req = '0;
      end
      serve(1'b0, 8'(k));
    end
    wait_drain();

    // 5. timeout on requester 1 (pointer is 1), master never busy
    req[1] = 1'b1;
    sb.push_back('{idx: 1, nack: 1'b1, tmo: 1'b1, rdata: 8'h00});
    wait_grant(1, 7'h11, 1'b0, 8'h81);
    req[1] = 1'b0;
    cyc = 0;
    while (done === '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_timeout_cycles",   32'(cyc),      32'd16);
    check("t5_m_enable_at_done", 32'(m_enable), 32'd0);
    // late busy from the master: no grant until it drops; spurious m_done ignored
    m_busy = 1'b1;
    req[0] = 1'b1;
    step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t5_no_grant_busy", 32'(grant), 32'd0);
    end
    sb.push_back('{idx: 0, nack: 1'b0, tmo: 1'b0, rdata: 8'h00});
    m_busy = 1'b0;
    wait_grant(0, 7'h10, 1'b0, 8'h80);
    req[0] = 1'b0;
    serve(1'b0, 8'h00);
    wait_drain();

    // 6. reset in WAIT_DONE on requester 2 (pointer 1), then 4'b1010 -> requester 1
    req[2] = 1'b1;
    wait_grant(2, 7'h12, 1'b0, 8'h82);
    req[2] = 1'b0;
    step();
    m_busy = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_grant",     32'(grant),     32'd0);
    check("t6_rst_done",      32'(done),      32'd0);
    check("t6_rst_m_enable",  32'(m_enable),  32'd0);
    check("t6_rst_m_address", 32'(m_address), 32'd0);
    step();
    rst    = 1'b0;
    m_busy = 1'b0;
    req    = 4'b1010;
    sb.push_back('{idx: 1, nack: 1'b0, tmo: 1'b0, rdata: 8'h00});
    wait_grant(1, 7'h11, 1'b0, 8'h81);
    req = '0;
    serve(1'b0, 8'h00);
    wait_drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_i2c_req_arbiter
